pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the pipelined RISC core, replacing the purely combinational next-PC select. It owns the PC register, resolves branch-select codes (BS/PS/Z), holds the PC under stall, and keeps a redirect that arrives during a stall pending until it can be applied. It issues a one-cycle flush to the fetch/decode stages. An optional return-address stack (RAS) serves call/return.

## Interface
- WIDTH, 32, address width of all PC/target buses
- INC, 1, sequential increment (word addressing)
- RESET_PC, 0, PC value loaded on reset
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2; used only with RAS_EN)

- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC this cycle
- bs  input  2  branch select: 00 seq, 01 conditional, 10 jump register, 11 unconditional
- ps  input  1  branch polarity
- z  input  1  zero flag from execute
- bra  input  WIDTH  branch target
- raa  input  WIDTH  register jump target
- link  input  1  push link_addr on a taken transfer (call)
- ret  input  1  with bs=10, pop RAS for the target (return)
- link_addr  input  WIDTH  return address to push
- pc  output  WIDTH  current fetch PC (registered)
- pc_1  output  WIDTH  pc + INC (combinational from pc)
- flush  output  1  registered; high one cycle when a redirect is applied
- pend  output  1  redirect captured and waiting on stall
- ras_empty, ras_full, ras_ovf  output  1 each  RAS status; ras_ovf is sticky

## Operation
- Taken (combinational): bs=01 → (z^ps); bs=10 or bs=11 → 1; bs=00 → 0.
- Target: bs=01/11 → bra. bs=10 → raa, or the RAS top when RAS_EN and ret and !ras_empty.
- Capture: a taken decision is captured in the same cycle regardless of stall. The target is stored in the pending register with pend=1, and RAS push/pop happens once at capture.
- PC update, first match wins:
  - reset → RESET_PC.
  - stall → hold.
  - captured now or pend → pc <= target (the new capture takes precedence over the old pend), pend<=0, flush<=1.
  - otherwise → pc <= pc_1 (wraps modulo 2^WIDTH), flush<=0.
- A new taken decision while pend=1 overwrites the pending target.
- bs=01 not taken behaves exactly as bs=00.
- RAS, circular with a count of 0..RAS_DEPTH:
  - push: link and taken. The top receives link_addr.
  - pop: bs=10 and ret and !empty.
  - push+pop same cycle: the top is replaced by link_addr; count unchanged.
  - push when full: the oldest entry is overwritten, count stays RAS_DEPTH, ras_ovf<=1 until reset.
  - pop when empty: the target falls back to raa, and the stack is unchanged.

## Timing
- Reset values: pc=RESET_PC, pc_1=RESET_PC+INC, flush=0, pend=0, ras_empty=1, ras_full=0, ras_ovf=0, count=0.
- Redirect latency: a taken decision in cycle N (stall=0) gives pc=target and flush=1 in cycle N+1.
- Under stall, the redirect applies on the first edge where stall=0; flush is high in the following cycle.
- pend is high from the cycle after capture until the cycle after application.
- Reset mid-pend: pending is discarded and the RAS is cleared.
- flush never lasts more than one cycle per applied redirect.
- No combinational path from any input to pc, flush or pend. pc_1 depends on pc only.

## Configuration
- RAS_EN defined: RAS instantiated with RAS_DEPTH entries; link/ret are active.
- RAS_EN undefined:
  - link, ret and link_addr are ignored.
  - bs=10 always targets raa.
  - ras_empty=1, ras_full=0, ras_ovf=0 constant.
  - No RAS storage is synthesised.

## Test plan
- Sequential and wrap: reset with RESET_PC=0xFFFFFFFE, stall=0, bs=00 → pc 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; flush stays 0.
- Conditional branch:
  - bs=01, ps=0, z=1, bra=0x100 → next pc=0x100 and flush=1 for one cycle.
  - bs=01, ps=1, z=1 → pc increments, flush=0.
- Stall + redirect:
  - bs=11, bra=0x40 with stall=1 for 3 cycles → pc held and pend=1.
  - On the first stall=0 edge: pc=0x40, flush=1 one cycle.
  - A second bs=10 with raa=0x80 during the stall → pc=0x80 instead.
- Call/return (RAS_EN): bs=11, link=1, bra=0x200, link_addr=0x11; then bs=10, ret=1, raa=0x999 → pc=0x200, then 0x11; ras_empty returns to 1.
- RAS overflow/underflow (RAS_EN, depth 4):
  - Five calls with link_addr 1..5 → ras_full=1, ras_ovf=1.
  - Five returns → targets 5, 4, 3, 2, then raa (empty fallback).
  - ras_ovf stays 1 until reset.
- Reset mid-operation: assert reset with pend=1 and RAS count=2 → next cycle pc=RESET_PC, pend=0, flush=0, ras_empty=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the pipelined RISC core.
//
// Owns the fetch PC and resolves the branch-select code (bs/ps/z) into a
// taken decision and a target. It holds the PC while stalled, and it keeps a
// redirect that arrives during a stall pending until the stall releases.
// Every applied redirect raises a one-cycle registered flush.
//
// Optional feature: define RAS_EN to build a circular return-address stack
// with RAS_DEPTH entries. Calls push with link, and returns pop with bs=10
// and ret. Without RAS_EN, link/ret/link_addr are ignored and the status
// outputs are constant (empty=1, full=0, ovf=0).
//
// Parameters: WIDTH (address width), INC (sequential step), RESET_PC,
//             RAS_DEPTH (power of two, >= 2).
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall               hold the PC this cycle
//   bs, ps, z           branch select, branch polarity, zero flag
//   bra, raa            branch target, register-jump target
//   link, ret           push on a taken transfer / pop on a bs=10 return
//   link_addr           return address to push
//   pc, pc_1            registered fetch PC and pc + INC
//   flush, pend         redirect applied last edge / redirect waiting on stall
//   ras_empty, ras_full, ras_ovf   RAS status (ras_ovf sticky until reset)

module pc_sequencer #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  INC       = WIDTH'(1),
    parameter logic [WIDTH-1:0]  RESET_PC  = '0,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       bs,
    input  logic             ps,
    input  logic             z,
    input  logic [WIDTH-1:0] bra,
    input  logic [WIDTH-1:0] raa,
    input  logic             link,
    input  logic             ret,
    input  logic [WIDTH-1:0] link_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_1,
    output logic             flush,
    output logic             pend,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf
);

    typedef enum logic [1:0] {
        BS_SEQ  = 2'b00,
        BS_COND = 2'b01,
        BS_JR   = 2'b10,
        BS_JMP  = 2'b11
    } bs_e;

    logic             taken;
    logic             use_ras;     // bs=10 return served from the stack top
    logic [WIDTH-1:0] ras_top;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pend_target;

    assign pc_1 = pc + INC;

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        taken  = 1'b0;
        target = bra;
        case (bs_e'(bs))
            BS_COND: taken = z ^ ps;
            BS_JR: begin
                taken  = 1'b1;
                target = use_ras ? ras_top : raa;
            end
            BS_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // PC, pending redirect and flush. A capture under stall is parked in
    // pend_target. A newer capture overwrites it and also wins on release.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            pend        <= 1'b0;
            pend_target <= '0;
            flush       <= 1'b0;
        end else if (stall) begin
            flush <= 1'b0;
            if (taken) begin
                pend        <= 1'b1;
                pend_target <= target;
            end
        end else if (taken) begin
            pc    <= target;
            pend  <= 1'b0;
            flush <= 1'b1;
        end else if (pend) begin
            pc    <= pend_target;
            pend  <= 1'b0;
            flush <= 1'b1;
        end else begin
            pc    <= pc_1;
            flush <= 1'b0;
        end
    end

`ifdef RAS_EN
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    top;
    logic [PW-1:0]    top_up;
    logic [CW-1:0]    count;
    logic             push;

    assign push      = link && taken;
    assign use_ras   = (bs == BS_JR) && ret && (count != '0);
    assign top_up    = top + PW'(1);
    assign ras_top   = ras_mem[top];
    assign ras_empty = (count == '0);
    assign ras_full  = (count == FULL);

    // The ring wraps naturally. A push while full lands on the oldest slot,
    // and the count saturates at RAS_DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            top     <= '0;
            count   <= '0;
            ras_ovf <= 1'b0;
        end else if (push && !use_ras) begin
            top <= top_up;
            if (count == FULL) ras_ovf <= 1'b1;
            else               count   <= count + CW'(1);
        end else if (use_ras && !push) begin
            top   <= top - PW'(1);
            count <= count - CW'(1);
        end
    end

    // NOTE: the stack storage has no reset. Entries are only read below a
    // valid count, so clearing top/count is enough, and the array can stay a
    // plain RAM.
    always_ff @(posedge clk) begin
        if (push) ras_mem[use_ras ? top : top_up] <= link_addr;
    end
`else
    logic unused_ras_inputs;

    assign unused_ras_inputs = ^{link, ret, link_addr, RAS_DEPTH[0]};
    assign use_ras   = 1'b0;
    assign ras_top   = '0;
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_ovf   = 1'b0;
`endif

endmodule
